// File: rtl/servo_pwm_gen_pkg.sv
// Shared definitions for the servo PWM transmitter: FSM state encoding and
// default timing constants (also used by the servo input filter thresholds).
package servo_pwm_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

  localparam int unsigned US_PER_S     = 1_000_000;
  localparam int unsigned DEF_CLK_HZ   = 50_000_000;
  localparam int unsigned DEF_FRAME_US = 20_000;
  localparam int unsigned DEF_MIN_US   = 1_000;
  localparam int unsigned DEF_MAX_US   = 2_000;
  localparam int unsigned DEF_POS_W    = 8;

endpackage

// File: rtl/servo_us_tick.sv
// Microsecond prescaler: one-clock us_tick every CLK_HZ/1e6 clocks while en=1;
// held at zero while disabled so a frame always starts on a fresh microsecond.
module servo_us_tick
  import servo_pwm_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEF_CLK_HZ
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic us_tick
);

  localparam int unsigned DIV   = CLK_HZ / US_PER_S;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en || cnt_q == LAST) cnt_d = '0;
    else                      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign us_tick = en && (cnt_q == LAST);

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM transmitter: one positive pulse per fixed frame, width linear in the
// commanded position; new positions take effect only at frame boundaries.
module servo_pwm_gen
  import servo_pwm_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ   = DEF_CLK_HZ,
  parameter int unsigned FRAME_US = DEF_FRAME_US,
  parameter int unsigned MIN_US   = DEF_MIN_US,
  parameter int unsigned MAX_US   = DEF_MAX_US,
  parameter int unsigned POS_W    = DEF_POS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [POS_W-1:0] pos,
  input  logic             pos_valid,
  output logic             pos_ready,
  output logic             out,
  output logic             frame_start
);

  localparam int unsigned US_W   = $clog2(FRAME_US);
  localparam int unsigned SPAN   = MAX_US - MIN_US;
  localparam int unsigned PROD_W = POS_W + 11;
  localparam logic [US_W-1:0] FRAME_LAST = US_W'(FRAME_US - 1);
  localparam logic [US_W-1:0] WIDTH_RST  = US_W'(MIN_US + SPAN / 2);

  if ((CLK_HZ % US_PER_S) != 0 || CLK_HZ < US_PER_S) begin : g_bad_clk
    $error("servo_pwm_gen: CLK_HZ must be a non-zero multiple of 1 MHz");
  end
  if (MAX_US >= FRAME_US || MIN_US > MAX_US || SPAN > 2047) begin : g_bad_width
    $error("servo_pwm_gen: need MIN_US <= MAX_US < FRAME_US and span below 2048 us");
  end

  pwm_state_e       state_q, state_d;
  logic [US_W-1:0]  us_cnt_q, us_cnt_d;
  logic [US_W-1:0]  act_w_q, act_w_d;
  logic [US_W-1:0]  pend_w_q, pend_w_d;
  logic             pend_full_q, pend_full_d;
  logic             out_q, out_d;
  logic             frame_start_q, frame_start_d;

  logic             us_tick;
  logic             frame_end;
  logic             frame_go;
  logic             accept;
  logic [US_W-1:0]  act_last;
  logic [PROD_W-1:0] prod;
  logic [US_W-1:0]  new_w;

  servo_us_tick #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .en      (state_q != ST_IDLE),
    .us_tick (us_tick)
  );

  assign prod      = PROD_W'(pos) * PROD_W'(SPAN);
  assign new_w     = US_W'(MIN_US) + US_W'(prod >> POS_W);
  assign act_last  = act_w_q - US_W'(1);
  assign frame_end = us_tick && (us_cnt_q == FRAME_LAST);
  assign frame_go  = enable && ((state_q == ST_IDLE) || (state_q == ST_LOW && frame_end));
  assign accept    = pos_valid && !pend_full_q;

  // out follows the HIGH state one clock later, so frame_start leads the rising edge
  always_comb begin
    state_d       = state_q;
    us_cnt_d      = us_cnt_q;
    act_w_d       = act_w_q;
    pend_w_d      = pend_w_q;
    pend_full_d   = pend_full_q;
    frame_start_d = frame_go;
    out_d         = (state_q == ST_HIGH);

    if (state_q == ST_IDLE) us_cnt_d = '0;
    else if (us_tick)       us_cnt_d = frame_end ? '0 : us_cnt_q + US_W'(1);

    unique case (state_q)
      ST_IDLE: if (enable) state_d = ST_HIGH;
      ST_HIGH: if (us_tick && us_cnt_q == act_last) state_d = ST_LOW;
      ST_LOW:  if (frame_end) state_d = enable ? ST_HIGH : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (frame_go && pend_full_q) begin
      act_w_d     = pend_w_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_w_d    = new_w;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      us_cnt_q      <= '0;
      act_w_q       <= WIDTH_RST;
      pend_w_q      <= '0;
      pend_full_q   <= 1'b0;
      out_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      us_cnt_q      <= us_cnt_d;
      act_w_q       <= act_w_d;
      pend_w_q      <= pend_w_d;
      pend_full_q   <= pend_full_d;
      out_q         <= out_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pos_ready   = !pend_full_q;
  assign out         = out_q;
  assign frame_start = frame_start_q;

endmodule
